// File: rtl/rename_map_table_pkg.sv
// rtl/rename_map_table_pkg.sv - shared types and default sizes for the rename map table
// Purpose: default geometry of the rename map plus the typedefs used to talk
//          about architectural registers, physical tags, checkpoint ids and maps.
// Ports:   none (package).
package rename_map_table_pkg;

  localparam int NUM_ARCH_REG_DEF = 16;
  localparam int NUM_PHYS_REG_DEF = 64;
  localparam int NUM_CKPT_DEF     = 4;

  localparam int AW_DEF = $clog2(NUM_ARCH_REG_DEF);
  localparam int PW_DEF = $clog2(NUM_PHYS_REG_DEF);
  localparam int CW_DEF = $clog2(NUM_CKPT_DEF);

  typedef logic [AW_DEF-1:0] arch_reg_t;
  typedef logic [PW_DEF-1:0] phys_reg_t;
  typedef logic [CW_DEF-1:0] ckpt_id_t;
  typedef phys_reg_t [NUM_ARCH_REG_DEF-1:0] map_t;

endpackage

// File: rtl/rename_map_table_ckpt_store.sv
// rtl/rename_map_table_ckpt_store.sv - circular buffer of branch checkpoint snapshots
// Purpose: holds up to NUM_CKPT copies of the speculative map, allocated at tail
//          and released from head; restore rewinds tail to just past the id.
// Ports:   clk, n_rst        clock, async active-low reset
//          alloc, snap_in     write snap_in into slot tail and advance tail
//          rel                release the oldest slot (head)
//          restore, restore_id  make restore_id the youngest live slot
//          clear              drop every checkpoint (full flush)
//          tail, count, full  allocation slot, live count, buffer full
//          snap_out           snapshot stored in slot restore_id
module rename_map_table_ckpt_store
  import rename_map_table_pkg::*;
#(
  parameter int NUM_ARCH_REG = NUM_ARCH_REG_DEF,
  parameter int NUM_CKPT     = NUM_CKPT_DEF,
  parameter int PW           = PW_DEF,
  localparam int CW          = $clog2(NUM_CKPT)
) (
  input  logic                             clk,
  input  logic                             n_rst,
  input  logic                             alloc,
  input  logic [NUM_ARCH_REG-1:0][PW-1:0]  snap_in,
  input  logic                             rel,
  input  logic                             restore,
  input  logic [CW-1:0]                    restore_id,
  input  logic                             clear,
  output logic [CW-1:0]                    tail,
  output logic [CW:0]                      count,
  output logic                             full,
  output logic [NUM_ARCH_REG-1:0][PW-1:0]  snap_out
);

  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW:0]   count_q, count_d;
  logic          rel_eff;
  logic [CW-1:0] restore_dist;

  logic [NUM_ARCH_REG-1:0][PW-1:0] snap_q [NUM_CKPT];

  // Slots are allocated in order, so the age of restore_id relative to head
  // is a plain modular difference; it stays live, everything younger is freed.
  assign restore_dist = restore_id - head_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rel_eff = rel && (count_q != '0);
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (restore) begin
      head_d  = head_q + CW'(rel_eff);
      tail_d  = restore_id + CW'(1);
      count_d = {1'b0, restore_dist} + (CW+1)'(1) - (CW+1)'(rel_eff);
    end else begin
      head_d  = head_q + CW'(rel_eff);
      tail_d  = tail_q + CW'(alloc);
      count_d = count_q + (CW+1)'(alloc) - (CW+1)'(rel_eff);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Snapshot storage carries no reset: a slot is only read once it was written.
  always_ff @(posedge clk) begin
    if (alloc) snap_q[tail_q] <= snap_in;
  end

  assign tail     = tail_q;
  assign count    = count_q;
  assign full     = (count_q == (CW+1)'(NUM_CKPT));
  assign snap_out = snap_q[restore_id];

  a_release_nonempty : assert property (@(posedge clk) disable iff (!n_rst)
    rel |-> (count_q != '0));
  a_restore_live : assert property (@(posedge clk) disable iff (!n_rst)
    restore |-> ({1'b0, restore_dist} < count_q));

endmodule

// File: rtl/rename_map_table.sv
// rtl/rename_map_table.sv - register rename map with branch checkpoints and committed map
// Purpose: translates architectural sources/dest to physical tags between decode
//          and dispatch; branch checkpoints allow mispredict recovery and the
//          committed map allows full flush recovery.
// Ports:   clk, n_rst                      clock, async active-low reset
//          rn_valid/rn_v_ra/rn_v_rt        rename request and source regs
//          rn_use_rw/rn_v_rw/rn_p_rw       dest write and its new physical tag
//          rn_ckpt                         branch: take a checkpoint
//          rn_p_ra/rn_p_rt/rn_p_old_rw     mapped sources, previous dest mapping
//          rn_ckpt_id/rn_stall             allocated checkpoint slot, rename refused
//          rs_valid/rs_id                  mispredict restore of a checkpoint
//          rl_valid                        release oldest checkpoint
//          cm_valid/cm_v_rw/cm_p_rw        commit of a dest write
//          flush                           restore committed map
//          ckpt_count                      live checkpoints
module rename_map_table
  import rename_map_table_pkg::*;
#(
  parameter int NUM_ARCH_REG = NUM_ARCH_REG_DEF,
  parameter int NUM_PHYS_REG = NUM_PHYS_REG_DEF,
  parameter int NUM_CKPT     = NUM_CKPT_DEF,
  localparam int AW          = $clog2(NUM_ARCH_REG),
  localparam int PW          = $clog2(NUM_PHYS_REG),
  localparam int CW          = $clog2(NUM_CKPT)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          rn_valid,
  input  logic [AW-1:0] rn_v_ra,
  input  logic [AW-1:0] rn_v_rt,
  input  logic          rn_use_rw,
  input  logic [AW-1:0] rn_v_rw,
  input  logic [PW-1:0] rn_p_rw,
  input  logic          rn_ckpt,
  output logic [PW-1:0] rn_p_ra,
  output logic [PW-1:0] rn_p_rt,
  output logic [PW-1:0] rn_p_old_rw,
  output logic [CW-1:0] rn_ckpt_id,
  output logic          rn_stall,
  input  logic          rs_valid,
  input  logic [CW-1:0] rs_id,
  input  logic          rl_valid,
  input  logic          cm_valid,
  input  logic [AW-1:0] cm_v_rw,
  input  logic [PW-1:0] cm_p_rw,
  input  logic          flush,
  output logic [CW:0]   ckpt_count
);

  logic [NUM_ARCH_REG-1:0][PW-1:0] spec_map_q, spec_map_d;
  logic [NUM_ARCH_REG-1:0][PW-1:0] arch_map_q, arch_map_d;
  logic [NUM_ARCH_REG-1:0][PW-1:0] snap_out;

  logic ckpt_full;
  logic rn_accept;
  logic ckpt_alloc;
  logic ckpt_restore;
  logic ckpt_release;

  // Flush and restore silently drop a rename instead of stalling it.
  assign rn_stall     = rn_valid & rn_ckpt & ckpt_full & ~flush & ~rs_valid;
  assign rn_accept    = rn_valid & ~flush & ~rs_valid & ~rn_stall;
  assign ckpt_alloc   = rn_accept & rn_ckpt;
  assign ckpt_restore = rs_valid & ~flush;
  assign ckpt_release = rl_valid & ~flush;

  // Sources read the registered map, so a same-cycle dest write is not seen.
  assign rn_p_ra     = spec_map_q[rn_v_ra];
  assign rn_p_rt     = spec_map_q[rn_v_rt];
  assign rn_p_old_rw = spec_map_q[rn_v_rw];

  always_comb begin
    arch_map_d = arch_map_q;
    if (cm_valid) arch_map_d[cm_v_rw] = cm_p_rw;
  end

  // The snapshot taken by a branch is spec_map_d, so it already holds the
  // branch's own dest write.
  always_comb begin
    spec_map_d = spec_map_q;
    if (flush) begin
      spec_map_d = arch_map_d;
    end else if (rs_valid) begin
      spec_map_d = snap_out;
    end else if (rn_accept && rn_use_rw) begin
      spec_map_d[rn_v_rw] = rn_p_rw;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_ARCH_REG; i++) begin
        spec_map_q[i] <= PW'(i);
        arch_map_q[i] <= PW'(i);
      end
    end else begin
      spec_map_q <= spec_map_d;
      arch_map_q <= arch_map_d;
    end
  end

  rename_map_table_ckpt_store #(
    .NUM_ARCH_REG (NUM_ARCH_REG),
    .NUM_CKPT     (NUM_CKPT),
    .PW           (PW)
  ) u_ckpt_store (
    .clk        (clk),
    .n_rst      (n_rst),
    .alloc      (ckpt_alloc),
    .snap_in    (spec_map_d),
    .rel        (ckpt_release),
    .restore    (ckpt_restore),
    .restore_id (rs_id),
    .clear      (flush),
    .tail       (rn_ckpt_id),
    .count      (ckpt_count),
    .full       (ckpt_full),
    .snap_out   (snap_out)
  );

endmodule
